stage1_drain: RTL and testbench

Result-drain engine on the read side of the stage-1 MAC array. On a single-cycle `capture` pulse it snapshots all 32 accumulator outputs into a shadow bank, freeing the array to start the next accumulation. It then streams the 32 results, rescaled and optionally rectified, one per transfer over a valid/ready interface. The consumer is the stage-2 input buffer or the CPU-side readout port.

---
 rtl/stage1_pkg.sv | 11 +
 rtl/stage1_act.sv | 23 ++
 rtl/stage1_drain.sv | 81 ++++++++
 tb/tb_stage1_drain.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stage1_pkg.sv
// Shared constants and types for the stage-1 MAC array read side.
// Also used by the stage-2 drain, so keep it free of block-specific logic.
package stage1_pkg;

  localparam int N_NEURONS = 32;
  localparam int ACC_W     = 32;
  localparam int IDX_W     = $clog2(N_NEURONS);

  typedef enum logic {IDLE, STREAM} drain_state_t;

endpackage

// File: rtl/stage1_act.sv
// Activation: fixed-point rescale by arithmetic shift, optional ReLU.
// Build option: define STAGE1_DRAIN_RELU_EN to clamp negative results to zero.
import stage1_pkg::*;

module stage1_act #(
  parameter int W     = ACC_W,
  parameter int SHIFT = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic signed [W-1:0] scaled;

  assign scaled = $signed(din) >>> SHIFT;

`ifdef STAGE1_DRAIN_RELU_EN
  assign dout = scaled[W-1] ? '0 : scaled;
`else
  assign dout = scaled;
`endif

endmodule

// File: rtl/stage1_drain.sv
// Result-drain engine: snapshots N accumulators on capture and streams them out.
// Build option: STAGE1_DRAIN_RELU_EN enables rectification in stage1_act.
import stage1_pkg::*;

module stage1_drain #(
  parameter int N     = N_NEURONS,
  parameter int W     = ACC_W,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [N*W-1:0]       p_flat,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
);

  localparam int            IW       = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  drain_state_t  state, state_next;
  logic [W-1:0]  bank [N];
  logic [IW-1:0] idx;
  logic          xfer, last_xfer, accept;

  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);
  // A capture landing on the final transfer is taken, giving gapless frames.
  assign accept    = capture && (state == IDLE || last_xfer);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = STREAM;
      STREAM:  if (last_xfer && !capture) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) bank[k] <= '0;
      idx <= '0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) bank[k] <= p_flat[k*W +: W];
      idx <= '0;
    end else if (xfer) begin
      idx <= last_xfer ? '0 : idx + 1'b1;
    end
  end

  // Sticky until reset: a frame arrived that the held bank could not accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         overrun <= 1'b0;
    else if (capture && state == STREAM && !last_xfer) overrun <= 1'b1;
  end

  always_comb begin
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
    out_last  = (state == STREAM) && (idx == LAST_IDX);
  end

  assign out_idx = idx;

  stage1_act #(.W(W), .SHIFT(SHIFT)) u_act (
    .din  (bank[idx]),
    .dout (out_data)
  );

endmodule

// File: tb/tb_stage1_drain.sv
// Scoreboard bench for stage1_drain: a frame-level model queues expected beats,
// a negedge monitor compares whatever the DUT presents.
module tb_stage1_drain;

  localparam int N     = 32;
  localparam int W     = 32;
  localparam int SHIFT = 8;
  localparam int IW    = $clog2(N);

  logic           clk;
  logic           reset;
  logic           capture;
  logic [N*W-1:0] p_flat;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic           overrun;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } exp_t;

  exp_t expQ[$];
  int   pending;
  bit   overrunExp;
  int   checks;
  int   errors;

  stage1_drain #(.N(N), .W(W), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .reset     (reset),
    .capture   (capture),
    .p_flat    (p_flat),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rescale as floor division by 2^SHIFT, then optional clamp at zero.
  function automatic logic [W-1:0] refResult(input logic [W-1:0] word);
    longint v, d, q;
    v = longint'($signed(word));
    d = longint'(1) << SHIFT;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
`ifdef STAGE1_DRAIN_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit cap, input bit rdy);
    capture   = cap;
    out_ready = rdy;
    @(posedge clk);
    #1;
    capture = 1'b0;
  endtask

  task automatic randomizeFrame();
    for (int k = 0; k < N; k++) p_flat[k*W +: W] = $urandom;
  endtask

  task automatic clearModel();
    expQ.delete();
    pending    = 0;
    overrunExp = 1'b0;
  endtask

  // Frame-level reference: a held frame has 'pending' beats left to deliver.
  always @(posedge clk) begin
    bit xferM;
    if (!reset) begin
      xferM = (pending > 0) && out_ready;
      if (capture && (pending == 0 || (pending == 1 && xferM))) begin
        for (int k = 0; k < N; k++)
          expQ.push_back('{data: refResult(p_flat[k*W +: W]), idx: k, last: (k == N-1)});
        pending = N;
      end else begin
        if (capture) overrunExp = 1'b1;
        if (xferM) pending--;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checkOutput("valid", 32'(out_valid), 32'(pending > 0));
      checkOutput("busy", 32'(busy), 32'(pending > 0));
      checkOutput("overrun", 32'(overrun), 32'(overrunExp));
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL beat: got unexpected beat idx %0d expected none at %0t", out_idx, $time);
        end else begin
          e = expQ[0];
          checkOutput("data", out_data, e.data);
          checkOutput("idx", 32'(out_idx), 32'(e.idx));
          checkOutput("last", 32'(out_last), 32'(e.last));
          if (out_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic drainAll();
    int budget;
    budget = 4 * N;
    while (pending > 0 && budget > 0) begin
      applyStimulus(1'b0, 1'b1);
      budget--;
    end
    if (pending > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d beats left expected 0", pending);
    end
    applyStimulus(1'b0, 1'b1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    capture = 1'b0;
    out_ready = 1'b0;
    p_flat  = '0;
    clearModel();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_idx", 32'(out_idx), 32'd0);
    checkOutput("rst_data", out_data, 32'd0);

    $display("[TB] ramp frame, always ready");
    for (int k = 0; k < N; k++) p_flat[k*W +: W] = W'(k * 256);
    applyStimulus(1'b1, 1'b1);
    randomizeFrame();
    drainAll();

    $display("[TB] negative value at index 3");
    randomizeFrame();
    p_flat[3*W +: W] = 32'hFFFF_FE00;
    applyStimulus(1'b1, 1'b1);
    drainAll();

    $display("[TB] backpressure at index 10");
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1);
    repeat (5)  applyStimulus(1'b0, 1'b0);
    drainAll();

    $display("[TB] overrun at index 5");
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b1);
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    drainAll();
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    drainAll();

    $display("[TB] back-to-back frames");
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    repeat (N-1) applyStimulus(1'b0, 1'b1);
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    drainAll();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      randomizeFrame();
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    drainAll();

    $display("[TB] async reset at index 17");
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    repeat (17) applyStimulus(1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_idx", 32'(out_idx), 32'd0);
    checkOutput("arst_overrun", 32'(overrun), 32'd0);
    clearModel();
    @(posedge clk);
    #1 reset = 1'b0;
    randomizeFrame();
    applyStimulus(1'b1, 1'b1);
    drainAll();

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
